ov7670_capture_scaled: RTL

//  Parametrised next-gen OV7670 pixel capture. Assembles byte pairs from the sensor's

---
 rtl/ov7670_capture_scaled.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ov7670_capture_scaled.sv
// OV7670 capture front-end: pairs sensor bytes into pixels, reformats them to 12 bits,
// decimates by 2^DEC_LOG2 and issues bounds-checked frame-buffer writes (pclk domain).
module ov7670_capture_scaled #(
    parameter int ADDR_W   = 17,
    parameter int DEPTH    = 76800,
    parameter int H_PIX    = 640,
    parameter int V_LINES  = 480,
    parameter int DEC_LOG2 = 1
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              capture_en,
    input  logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              overflow
);
    localparam int XW       = $clog2(H_PIX) + 1;
    localparam int YW       = $clog2(V_LINES) + 1;
    localparam int DEC_MASK = (1 << DEC_LOG2) - 1;

    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic              armed_q, armed_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic              fd_q, fd_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              ovf_q, ovf_d;

    function automatic logic dec_keep(input logic [XW-1:0] xv, input logic [YW-1:0] yv);
        return ((int'(xv) | int'(yv)) & DEC_MASK) == 0;
    endfunction

    always_comb begin
        vsync_d = vsync;
        href_d  = href;
        armed_d = armed_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        we_d    = 1'b0;
        fd_d    = 1'b0;
        fcnt_d  = fcnt_q;
        ovf_d   = ovf_q;

        // addr shows the address of the write while we is high, then advances
        if (we_q) addr_d = addr_q + 1'b1;

        if (vsync || !href) begin
            phase_d = 1'b0;
        end else begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = d;
            end else begin
                if (armed_q && dec_keep(x_q, y_q)) begin
                    if (int'(x_q) < H_PIX && int'(y_q) < V_LINES && int'(addr_q) < DEPTH) begin
                        we_d   = 1'b1;
                        dout_d = mode ? {hi_q, hi_q[7:4]}
                                      : {hi_q[7:4], hi_q[2:0], d[7], d[4:1]};
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (x_q != '1) x_d = x_q + 1'b1;
            end
        end

        if (href_q && !href) begin
            x_d = '0;
            if (x_q != '0 && y_q != '1) y_d = y_q + 1'b1;
        end

        if (vsync_q && !vsync) begin
            armed_d = capture_en;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            ovf_d   = 1'b0;
        end

        if (!vsync_q && vsync && armed_q) begin
            fd_d    = 1'b1;
            fcnt_d  = fcnt_q + 1'b1;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            armed_q <= 1'b0;
            phase_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            fd_q    <= 1'b0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            armed_q <= armed_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            fd_q    <= fd_d;
            fcnt_q  <= fcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The high byte is pure data and is always rewritten before it is consumed
    always_ff @(posedge pclk) begin
        hi_q <= hi_d;
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = fd_q;
    assign frame_cnt  = fcnt_q;
    assign overflow   = ovf_q;
endmodule
